hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_pkg.sv | 26 ++
 rtl/hazard_src_match.sv | 15 +
 rtl/hazard_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the load-use hazard controller: FSM encoding, load opcode,
// register-address widths and the writing-load decode.
package hazard_pkg;

  localparam int OP_W     = 4;
  localparam int DST_W    = 5;
  localparam int REG_AW   = 3;
  localparam int NUM_REGS = 1 << REG_AW;
  localparam int CNT_W    = 3;
  localparam int HOLD_W   = 8;

  localparam logic [OP_W-1:0] LOAD_OP = 4'b1110;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  // A load only occupies the scoreboard when it targets the writable register space.
  function automatic logic is_writing_load(input logic [OP_W-1:0] op,
                                           input logic [DST_W-1:0] dst);
    return (op == LOAD_OP) && (dst[4] | dst[3]);
  endfunction

endpackage

// File: rtl/hazard_src_match.sv
// Per-source RAW hit detection of decode operands against the pending-load mask.
module src_match
  import hazard_pkg::*;
(
  input  logic [NUM_REGS-1:0] pend_mask_i,
  input  logic [REG_AW-1:0]   src1_i,
  input  logic [REG_AW-1:0]   src2_i,
  input  logic [1:0]          src_en_i,
  output logic [1:0]          hit_o
);

  assign hit_o[0] = src_en_i[0] & pend_mask_i[src1_i];
  assign hit_o[1] = src_en_i[1] & pend_mask_i[src2_i];

endmodule

// File: rtl/hazard_ctrl.sv
// Load scoreboard and decode stall controller with RUN/HOLD/FLUSH timeout recovery.
// Optional build macro HAZARD_PERF_EN adds a saturating 16-bit stall_count output.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MAX_PEND = 2,
  parameter int TIMEOUT  = 15
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                id_valid,
  input  logic [OP_W-1:0]     id_op,
  input  logic [DST_W-1:0]    id_dst,
  input  logic [REG_AW-1:0]   id_src1,
  input  logic [REG_AW-1:0]   id_src2,
  input  logic [1:0]          id_src_en,
  input  logic                wb_valid,
  input  logic [REG_AW-1:0]   wb_dst,
  output logic                stall,
  output logic                issue,
  output logic [NUM_REGS-1:0] pend_mask,
  output logic [CNT_W-1:0]    pend_cnt,
  output logic                err
`ifdef HAZARD_PERF_EN
  ,
  output logic [15:0]         stall_count
`endif
);

  state_e              state_q, state_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [NUM_REGS-1:0] mask_q, mask_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;

  logic [1:0]        src_hit;
  logic              wr_load, waw, full, hazard, active;
  logic              set_en, clr_en, same, inc, dec;
  logic [REG_AW-1:0] set_idx;

  src_match u_src_match (
    .pend_mask_i (mask_q),
    .src1_i      (id_src1),
    .src2_i      (id_src2),
    .src_en_i    (id_src_en),
    .hit_o       (src_hit)
  );

  // Hazards look only at the registered mask, so a writeback releases the stall a cycle later.
  assign wr_load = is_writing_load(id_op, id_dst);
  assign waw     = wr_load & mask_q[id_dst[REG_AW-1:0]];
  assign full    = wr_load & (cnt_q == CNT_W'(MAX_PEND));
  assign hazard  = (|src_hit) | waw | full;
  assign active  = ~reset & id_valid & (state_q != ST_FLUSH);
  assign stall   = active & hazard;
  assign issue   = active & ~hazard;

  assign set_en  = issue & wr_load;
  assign set_idx = id_dst[REG_AW-1:0];
  assign clr_en  = wb_valid & mask_q[wb_dst];
  // Coincident set and writeback to one register: the bit stays set and the count is left alone.
  assign same    = set_en & wb_valid & (wb_dst == set_idx);
  assign inc     = set_en & ~same;
  assign dec     = clr_en & ~same & (cnt_q != '0);

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    err_d   = err_q;
    unique case (state_q)
      ST_RUN: begin
        hold_d = '0;
        if (stall) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (!stall) begin
          state_d = ST_RUN;
          hold_d  = '0;
        end else if (hold_q == HOLD_W'(TIMEOUT - 1)) begin
          state_d = ST_FLUSH;
          hold_d  = HOLD_W'(TIMEOUT);
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      ST_FLUSH: begin
        state_d = ST_RUN;
        hold_d  = '0;
        err_d   = 1'b1;
      end
      default: begin
        state_d = ST_RUN;
        hold_d  = '0;
      end
    endcase
  end

  always_comb begin
    mask_d = mask_q;
    cnt_d  = cnt_q;
    if (state_q == ST_FLUSH) begin
      mask_d = '0;
      cnt_d  = '0;
    end else begin
      if (clr_en && !same) mask_d[wb_dst] = 1'b0;
      if (set_en)          mask_d[set_idx] = 1'b1;
      cnt_d = cnt_q + CNT_W'(inc) - CNT_W'(dec);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
      hold_q  <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign pend_mask = mask_q;
  assign pend_cnt  = cnt_q;
  assign err       = err_q;

`ifdef HAZARD_PERF_EN
  logic [15:0] stall_count_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                  stall_count_q <= '0;
    else if (stall && stall_count_q != 16'hFFFF) stall_count_q <= stall_count_q + 16'd1;
  end

  assign stall_count = stall_count_q;
`else
  // Stall counter is not built in this configuration.
`endif

endmodule
